// File: rtl/smash_pkg.sv
// Shared types for the game state manager: player life states and ctrl_word bit map.
package smash_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_KO      = 2'd1,
        ST_RESPAWN = 2'd2,
        ST_OUT     = 2'd3
    } player_state_t;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    localparam int unsigned CTRL_RUMBLE1   = 0;
    localparam int unsigned CTRL_RUMBLE2   = 1;
    localparam int unsigned CTRL_PHYS_RST1 = 2;
    localparam int unsigned CTRL_PHYS_RST2 = 3;
    localparam int unsigned CTRL_GAME_OVER = 4;
    localparam int unsigned CTRL_WINNER    = 5;
    localparam int unsigned CTRL_DRAW      = 6;

endpackage

// File: rtl/player_life_fsm.sv
// One player's life cycle: damage accumulation, lives, KO / respawn sequencing and pulse timers.
module player_life_fsm
    import smash_pkg::*;
#(
    parameter int unsigned START_LIVES     = 3,
    parameter int unsigned DMG_MAX         = 999,
    parameter int unsigned PHYS_RST_CYCLES = 4,
    parameter int unsigned RESPAWN_CYCLES  = 50_000_000,
    parameter int unsigned RUMBLE_CYCLES   = 25_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               game_start,
    input  logic               freeze,
    input  logic               oob,
    input  logic [HALF_W-1:0]  dmg_inc,
    input  logic               dmg_valid,
    output player_state_t      state,
    output logic [HALF_W-1:0]  lives,
    output logic [HALF_W-1:0]  damage,
    output logic               phys_rst,
    output logic               rumble
);

    localparam logic [CNT_W-1:0]  PHYS_LOAD   = CNT_W'(PHYS_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RESP_LOAD   = CNT_W'(RESPAWN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RUMBLE_LOAD = CNT_W'(RUMBLE_CYCLES - 1);
    localparam logic [HALF_W-1:0] LIVES_INIT  = HALF_W'(START_LIVES);
    localparam logic [HALF_W-1:0] DMG_SAT     = HALF_W'(DMG_MAX);

    logic [CNT_W-1:0]  phys_cnt;
    logic [CNT_W-1:0]  rumble_cnt;
    logic [CNT_W-1:0]  resp_cnt;
    logic [HALF_W:0]   dmg_sum;

    assign dmg_sum = {1'b0, damage} + {1'b0, dmg_inc};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_ALIVE;
            lives      <= LIVES_INIT;
            damage     <= '0;
            phys_rst   <= 1'b0;
            rumble     <= 1'b0;
            phys_cnt   <= '0;
            rumble_cnt <= '0;
            resp_cnt   <= '0;
        end else if (game_start) begin
            state      <= ST_RESPAWN;
            lives      <= LIVES_INIT;
            damage     <= '0;
            phys_rst   <= 1'b1;
            phys_cnt   <= PHYS_LOAD;
            rumble     <= 1'b0;
            rumble_cnt <= '0;
            resp_cnt   <= RESP_LOAD;
        end else if (!freeze) begin
            // Pulse timers run independently of the state; a KO below reloads them.
            if (phys_rst) begin
                if (phys_cnt == '0) phys_rst <= 1'b0;
                else                phys_cnt <= phys_cnt - 1'b1;
            end
            if (rumble) begin
                if (rumble_cnt == '0) rumble     <= 1'b0;
                else                  rumble_cnt <= rumble_cnt - 1'b1;
            end

            unique case (state)
                ST_ALIVE: begin
                    if (oob) begin
                        state      <= ST_KO;
                        lives      <= (lives == '0) ? '0 : lives - 1'b1;
                        damage     <= '0;
                        phys_rst   <= 1'b1;
                        phys_cnt   <= PHYS_LOAD;
                        rumble     <= 1'b1;
                        rumble_cnt <= RUMBLE_LOAD;
                    end else if (dmg_valid) begin
                        damage <= (dmg_sum > {1'b0, DMG_SAT}) ? DMG_SAT : dmg_sum[HALF_W-1:0];
                    end
                end
                ST_KO: begin
                    if (phys_cnt == '0) begin
                        state    <= (lives == '0) ? ST_OUT : ST_RESPAWN;
                        resp_cnt <= RESP_LOAD;
                    end
                end
                ST_RESPAWN: begin
                    if (resp_cnt == '0) state    <= ST_ALIVE;
                    else                resp_cnt <= resp_cnt - 1'b1;
                end
                ST_OUT: begin
                    state <= ST_OUT;
                end
                default: state <= ST_ALIVE;
            endcase
        end
    end

endmodule

// File: rtl/game_state_manager.sv
// Two-player match supervisor: blast-zone detection, game-over / winner resolution and mmio packing.
module game_state_manager
    import smash_pkg::*;
#(
    parameter int unsigned START_LIVES     = 3,
    parameter int unsigned DMG_MAX         = 999,
    parameter int unsigned X_MAX           = 1023,
    parameter int unsigned Y_MAX           = 767,
    parameter int unsigned PHYS_RST_CYCLES = 4,
    parameter int unsigned RESPAWN_CYCLES  = 50_000_000,
    parameter int unsigned RUMBLE_CYCLES   = 25_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              game_start,
    input  logic [WORD_W-1:0] pos1,
    input  logic [WORD_W-1:0] pos2,
    input  logic [HALF_W-1:0] dmg1_inc,
    input  logic [HALF_W-1:0] dmg2_inc,
    input  logic              dmg1_valid,
    input  logic              dmg2_valid,
    input  logic [WORD_W-1:0] size1,
    input  logic [WORD_W-1:0] size2,
    output logic [WORD_W-1:0] ctrl_word,
    output logic [WORD_W-1:0] damage1,
    output logic [WORD_W-1:0] damage2,
    output logic [WORD_W-1:0] size1_out,
    output logic [WORD_W-1:0] size2_out,
    output logic [WORD_W-1:0] lives1,
    output logic [WORD_W-1:0] lives2
);

    localparam logic [HALF_W-1:0] X_LIM = HALF_W'(X_MAX);
    localparam logic [HALF_W-1:0] Y_LIM = HALF_W'(Y_MAX);

    logic [WORD_W-1:0] pos1_q, pos2_q;
    logic              oob1, oob2;
    logic              game_over, winner, draw;
    player_state_t     state1, state2;
    logic [HALF_W-1:0] lives1_q, lives2_q, damage1_q, damage2_q;
    logic              phys_rst1, phys_rst2, rumble1, rumble2;
    logic              out1, out2;

    // Unsigned compare: negative coordinates wrap high and land out of bounds.
    assign oob1 = (pos1_q[31:16] > X_LIM) || (pos1_q[15:0] > Y_LIM);
    assign oob2 = (pos2_q[31:16] > X_LIM) || (pos2_q[15:0] > Y_LIM);
    assign out1 = (state1 == ST_OUT);
    assign out2 = (state2 == ST_OUT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pos1_q    <= '0;
            pos2_q    <= '0;
            size1_out <= '0;
            size2_out <= '0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            draw      <= 1'b0;
        end else begin
            pos1_q <= pos1;
            pos2_q <= pos2;
            if (game_start) begin
                size1_out <= size1;
                size2_out <= size2;
                game_over <= 1'b0;
                winner    <= 1'b0;
                draw      <= 1'b0;
            end else if (!game_over) begin
                size1_out <= size1;
                size2_out <= size2;
                if (out1 || out2) begin
                    game_over <= 1'b1;
                    draw      <= out1 && out2;
                    winner    <= out1 && !out2;
                end
            end
        end
    end

    player_life_fsm #(
        .START_LIVES(START_LIVES), .DMG_MAX(DMG_MAX), .PHYS_RST_CYCLES(PHYS_RST_CYCLES),
        .RESPAWN_CYCLES(RESPAWN_CYCLES), .RUMBLE_CYCLES(RUMBLE_CYCLES)
    ) u_p1 (
        .clock(clock), .reset(reset), .game_start(game_start), .freeze(game_over),
        .oob(oob1), .dmg_inc(dmg1_inc), .dmg_valid(dmg1_valid), .state(state1),
        .lives(lives1_q), .damage(damage1_q), .phys_rst(phys_rst1), .rumble(rumble1)
    );

    player_life_fsm #(
        .START_LIVES(START_LIVES), .DMG_MAX(DMG_MAX), .PHYS_RST_CYCLES(PHYS_RST_CYCLES),
        .RESPAWN_CYCLES(RESPAWN_CYCLES), .RUMBLE_CYCLES(RUMBLE_CYCLES)
    ) u_p2 (
        .clock(clock), .reset(reset), .game_start(game_start), .freeze(game_over),
        .oob(oob2), .dmg_inc(dmg2_inc), .dmg_valid(dmg2_valid), .state(state2),
        .lives(lives2_q), .damage(damage2_q), .phys_rst(phys_rst2), .rumble(rumble2)
    );

    always_comb begin
        ctrl_word                 = '0;
        ctrl_word[CTRL_RUMBLE1]   = rumble1;
        ctrl_word[CTRL_RUMBLE2]   = rumble2;
        ctrl_word[CTRL_PHYS_RST1] = phys_rst1;
        ctrl_word[CTRL_PHYS_RST2] = phys_rst2;
        ctrl_word[CTRL_GAME_OVER] = game_over;
        ctrl_word[CTRL_WINNER]    = winner;
        ctrl_word[CTRL_DRAW]      = draw;
    end

    assign damage1 = {16'h0000, damage1_q};
    assign damage2 = {16'h0000, damage2_q};
    assign lives1  = {16'h0000, lives1_q};
    assign lives2  = {16'h0000, lives2_q};

endmodule

// File: tb/tb_game_state_manager.sv
// Directed bench for game_state_manager with shortened timing parameters.
module tb_game_state_manager;

    logic        clock = 1'b0;
    logic        reset;
    logic        game_start;
    logic [31:0] pos1, pos2, size1, size2;
    logic [15:0] dmg1_inc, dmg2_inc;
    logic        dmg1_valid, dmg2_valid;
    logic [31:0] ctrl_word, damage1, damage2, size1_out, size2_out, lives1, lives2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] i1;
        logic        v1;
        logic [15:0] i2;
        logic        v2;
        logic [15:0] e1;
        logic [15:0] e2;
    } dvec_t;

    dvec_t vecs [5];

    game_state_manager #(
        .START_LIVES(2), .PHYS_RST_CYCLES(4), .RESPAWN_CYCLES(10), .RUMBLE_CYCLES(6)
    ) dut (
        .clock(clock), .reset(reset), .game_start(game_start),
        .pos1(pos1), .pos2(pos2),
        .dmg1_inc(dmg1_inc), .dmg2_inc(dmg2_inc),
        .dmg1_valid(dmg1_valid), .dmg2_valid(dmg2_valid),
        .size1(size1), .size2(size2),
        .ctrl_word(ctrl_word), .damage1(damage1), .damage2(damage2),
        .size1_out(size1_out), .size2_out(size2_out),
        .lives1(lives1), .lives2(lives2)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_game_over(input string name, input int exp_ticks);
        int n;
        n = 0;
        while (!ctrl_word[4] && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'(exp_ticks));
    endtask

    initial begin
        int pc, rc;

        vecs[0] = '{16'd600,   1'b1, 16'd0,    1'b0, 16'd600, 16'd0};
        vecs[1] = '{16'd600,   1'b1, 16'd400,  1'b1, 16'd999, 16'd400};
        vecs[2] = '{16'd0,     1'b0, 16'd599,  1'b1, 16'd999, 16'd999};
        vecs[3] = '{16'd65535, 1'b1, 16'd1000, 1'b1, 16'd999, 16'd999};
        vecs[4] = '{16'd7,     1'b0, 16'd7,    1'b0, 16'd999, 16'd999};

        reset = 1'b0; game_start = 1'b0;
        pos1 = '0; pos2 = '0; dmg1_inc = '0; dmg2_inc = '0;
        dmg1_valid = 1'b0; dmg2_valid = 1'b0;
        size1 = 32'h0010_0020; size2 = 32'h0030_0040;

        // Test 1: reset state
        #12;
        chk("rst_lives1", lives1, 32'd2);
        chk("rst_lives2", lives2, 32'd2);
        chk("rst_damage1", damage1, 32'd0);
        chk("rst_damage2", damage2, 32'd0);
        chk("rst_ctrl", ctrl_word, 32'd0);
        chk("rst_size1", size1_out, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("size1_pass", size1_out, 32'h0010_0020);
        chk("size2_pass", size2_out, 32'h0030_0040);

        // Corner of the arena is still in bounds
        pos1 = 32'h03FF_02FF;
        repeat (3) tick();
        chk("inbound_lives1", lives1, 32'd2);
        chk("inbound_ctrl", ctrl_word, 32'd0);
        pos1 = '0;
        tick();

        // Test 2: damage accumulation and saturation
        for (int i = 0; i < 5; i++) begin
            dmg1_inc = vecs[i].i1; dmg1_valid = vecs[i].v1;
            dmg2_inc = vecs[i].i2; dmg2_valid = vecs[i].v2;
            tick();
            chk($sformatf("dmg1_v%0d", i), damage1, {16'h0, vecs[i].e1});
            chk($sformatf("dmg2_v%0d", i), damage2, {16'h0, vecs[i].e2});
        end
        dmg1_valid = 1'b0; dmg2_valid = 1'b0;

        // Test 3/4: KO sequence, pulse lengths, strobes ignored until ALIVE
        pos1 = 32'h0500_0100;
        tick();
        tick();
        chk("ko_lives1", lives1, 32'd1);
        chk("ko_damage1", damage1, 32'd0);
        pos1 = '0; dmg1_inc = 16'd5; dmg1_valid = 1'b1;
        pc = ctrl_word[2] ? 1 : 0;
        rc = ctrl_word[0] ? 1 : 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (ctrl_word[2]) pc++;
            if (ctrl_word[0]) rc++;
            if (k == 14) chk("respawn_dmg_ignored", damage1, 32'd0);
        end
        chk("alive_dmg_accepted", damage1, 32'd5);
        chk("phys_rst1_len", 32'(pc), 32'd4);
        chk("rumble1_len", 32'(rc), 32'd6);
        dmg1_valid = 1'b0;

        // Test 5: second KO takes P1 out
        pos1 = 32'h0500_0100;
        tick();
        tick();
        pos1 = '0;
        chk("p1_lives0", lives1, 32'd0);
        wait_game_over("p1_out_latency", 5);
        chk("p1_out_winner", 32'(ctrl_word[5]), 32'd1);
        chk("p1_out_draw", 32'(ctrl_word[6]), 32'd0);
        size1 = 32'hDEAD_BEEF;
        pos2 = 32'h0500_0100;
        repeat (3) tick();
        pos2 = '0;
        repeat (3) tick();
        chk("frozen_lives2", lives2, 32'd2);
        chk("frozen_size1", size1_out, 32'h0010_0020);
        chk("frozen_ctrl", ctrl_word & 32'h0000_007E, 32'h0000_0030);
        size1 = 32'h0010_0020;

        // Test 6: new game, then simultaneous elimination
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        chk("gs_ctrl", ctrl_word, 32'h0000_000C);
        chk("gs_lives1", lives1, 32'd2);
        chk("gs_lives2", lives2, 32'd2);
        chk("gs_damage2", damage2, 32'd0);
        pc = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (ctrl_word[2] && ctrl_word[3]) pc++;
        end
        chk("gs_phys_len", 32'(pc), 32'd4);
        repeat (4) tick();

        pos1 = 32'h0400_0000; pos2 = 32'h0000_FFFF;
        tick();
        tick();
        pos1 = '0; pos2 = '0;
        chk("both_ko_lives1", lives1, 32'd1);
        chk("both_ko_lives2", lives2, 32'd1);
        repeat (16) tick();
        pos1 = 32'h0000_0300; pos2 = 32'h0500_0100;
        tick();
        tick();
        pos1 = '0; pos2 = '0;
        chk("both_out_lives1", lives1, 32'd0);
        chk("both_out_lives2", lives2, 32'd0);
        wait_game_over("draw_latency", 5);
        chk("draw_bit", 32'(ctrl_word[6]), 32'd1);
        chk("draw_winner", 32'(ctrl_word[5]), 32'd0);

        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        chk("gs2_ctrl", ctrl_word, 32'h0000_000C);
        chk("gs2_lives1", lives1, 32'd2);
        chk("gs2_lives2", lives2, 32'd2);
        pc = 1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (ctrl_word[2] && ctrl_word[3]) pc++;
        end
        chk("gs2_phys_len", 32'(pc), 32'd4);

        // Reset in the middle of RESPAWN leaves nothing behind
        reset = 1'b0;
        #1;
        chk("midrst_ctrl", ctrl_word, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) tick();
        chk("postrst_ctrl", ctrl_word, 32'd0);
        chk("postrst_lives1", lives1, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
